// File: rtl/padd_pkg.sv
// Shared types and saturating arithmetic helpers for the symmetric pre-adder tap.
// The saturating path of padd_sym_tap is built only when PADD_SAT_EN is defined.
package padd_pkg;

   localparam int W_DEFAULT = 18;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      PRIMED  = 2'd2
   } fill_state_e;

   typedef struct packed {
      logic        ovf;
      logic [63:0] res;
   } sat_res_t;

   // Clamp a wide signed result into the signed range of a w-bit word.
   function automatic sat_res_t sat_clamp(input logic signed [64:0] s, input int w);
      logic signed [64:0] mx;
      logic signed [64:0] mn;
      sat_res_t           r;
      mx    = (65'sd1 <<< (w - 1)) - 65'sd1;
      mn    = -(65'sd1 <<< (w - 1));
      r.ovf = (s > mx) || (s < mn);
      if (s > mx)      r.res = mx[63:0];
      else if (s < mn) r.res = mn[63:0];
      else             r.res = s[63:0];
      return r;
   endfunction

   function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                        input logic signed [63:0] b, input int w);
      return sat_clamp(65'(a) + 65'(b), w);
   endfunction

   function automatic sat_res_t sat_sub(input logic signed [63:0] a,
                                        input logic signed [63:0] b, input int w);
      return sat_clamp(65'(a) - 65'(b), w);
   endfunction

endpackage

// File: rtl/padd_chain_sreg.sv
// W x DEPTH shift register with clock enable and async active-low clear.
// Exposes the first stage (head) and the last stage (tail).
module padd_chain_sreg #(
   parameter int W     = 18,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] head,
   output logic [W-1:0] tail
);

   logic [DEPTH-1:0][W-1:0] r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r <= '0;
      end else if (ce) begin
         r[0] <= d;
         for (int k = 1; k < DEPTH; k++) r[k] <= r[k-1];
      end
   end

   assign head = r[0];
   assign tail = r[DEPTH-1];

endmodule

// File: rtl/padd_sym_tap.sv
// Cascadable symmetric-FIR pre-adder tap: forward/backward sample chains, pre-add
// register and fill tracking. Define PADD_SAT_EN for saturating dout plus sat_flag.
module padd_sym_tap
   import padd_pkg::*;
#(
   parameter int W       = W_DEFAULT,
   parameter int DEPTH   = 1,
   parameter int ADD_SUB = 0
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ce,
   input  logic [W-1:0] si,
   input  logic [W-1:0] sbi,
   input  logic         in_valid,
   output logic [W-1:0] so,
   output logic [W-1:0] sbo,
   output logic [W-1:0] dout,
   output logic         dout_valid,
`ifdef PADD_SAT_EN
   output logic         sat_flag,
`endif
   output logic         primed
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  f0, b0, dout_nx;
   logic          v0, v_tail_unused;
   fill_state_e   state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          primed_next;

   padd_chain_sreg #(.W(W), .DEPTH(DEPTH)) u_fwd (
      .clk(clk), .resetn(resetn), .ce(ce), .d(si), .head(f0), .tail(so));

   padd_chain_sreg #(.W(W), .DEPTH(DEPTH)) u_bwd (
      .clk(clk), .resetn(resetn), .ce(ce), .d(sbi), .head(b0), .tail(sbo));

   padd_chain_sreg #(.W(1), .DEPTH(DEPTH)) u_vld (
      .clk(clk), .resetn(resetn), .ce(ce), .d(in_valid), .head(v0), .tail(v_tail_unused));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= EMPTY;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Any bubble discards the fill, so priming needs DEPTH back-to-back valid samples.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (ce) begin
         if (!in_valid) begin
            state_nx = EMPTY;
            cnt_nx   = '0;
         end else begin
            case (state)
               EMPTY: begin
                  cnt_nx   = CW'(1);
                  state_nx = (DEPTH == 1) ? PRIMED : FILLING;
               end
               FILLING: begin
                  cnt_nx = cnt + 1'b1;
                  if (cnt == CW'(DEPTH - 1)) state_nx = PRIMED;
               end
               PRIMED: ;
               default: begin
                  state_nx = EMPTY;
                  cnt_nx   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      primed      = (state == PRIMED);
      primed_next = (state_nx == PRIMED);
   end

`ifdef PADD_SAT_EN
   sat_res_t sat_r;
   logic     sat_nx;

   always_comb begin
      sat_r   = (ADD_SUB != 0) ? sat_sub(64'(signed'(f0)), 64'(signed'(b0)), W)
                               : sat_add(64'(signed'(f0)), 64'(signed'(b0)), W);
      dout_nx = sat_r.res[W-1:0];
      sat_nx  = sat_r.ovf;
   end
`else
   always_comb dout_nx = (ADD_SUB != 0) ? (f0 - b0) : (f0 + b0);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dout       <= '0;
         dout_valid <= 1'b0;
`ifdef PADD_SAT_EN
         sat_flag   <= 1'b0;
`endif
      end else if (ce) begin
         dout       <= dout_nx;
         dout_valid <= v0 & primed_next;
`ifdef PADD_SAT_EN
         sat_flag   <= sat_nx;
`endif
      end
   end

endmodule

// File: tb/tb_padd_sym_tap.sv
// Self-checking bench for padd_sym_tap: three taps (DEPTH 1/4 add, DEPTH 2 subtract)
// share one stimulus stream and are compared every cycle against a history-based model.
module tb_padd_sym_tap;

   localparam int W = 18;
   localparam longint MAXP = (64'sd1 <<< (W - 1)) - 1;
   localparam longint MINN = -(64'sd1 <<< (W - 1));

   logic         clk = 1'b0;
   logic         resetn = 1'b1;
   logic         ce = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] si = '0;
   logic [W-1:0] sbi = '0;

   logic [W-1:0] so1, sbo1, d1, so4, sbo4, d4, so2, sbo2, d2;
   logic         dv1, pr1, dv4, pr4, dv2, pr2;
`ifdef PADD_SAT_EN
   logic         sf1, sf4, sf2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   padd_sym_tap #(.W(W), .DEPTH(1), .ADD_SUB(0)) u1 (
      .clk(clk), .resetn(resetn), .ce(ce), .si(si), .sbi(sbi), .in_valid(in_valid),
      .so(so1), .sbo(sbo1), .dout(d1), .dout_valid(dv1),
`ifdef PADD_SAT_EN
      .sat_flag(sf1),
`endif
      .primed(pr1));

   padd_sym_tap #(.W(W), .DEPTH(4), .ADD_SUB(0)) u4 (
      .clk(clk), .resetn(resetn), .ce(ce), .si(si), .sbi(sbi), .in_valid(in_valid),
      .so(so4), .sbo(sbo4), .dout(d4), .dout_valid(dv4),
`ifdef PADD_SAT_EN
      .sat_flag(sf4),
`endif
      .primed(pr4));

   padd_sym_tap #(.W(W), .DEPTH(2), .ADD_SUB(1)) u2 (
      .clk(clk), .resetn(resetn), .ce(ce), .si(si), .sbi(sbi), .in_valid(in_valid),
      .so(so2), .sbo(sbo2), .dout(d2), .dout_valid(dv2),
`ifdef PADD_SAT_EN
      .sat_flag(sf2),
`endif
      .primed(pr2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: history of every ce-cycle input accepted since the last reset.
   logic [W-1:0] q_si[$];
   logic [W-1:0] q_sbi[$];
   bit           q_v[$];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_si.delete(); q_sbi.delete(); q_v.delete();
      end else if (ce) begin
         q_si.push_back(si); q_sbi.push_back(sbi); q_v.push_back(in_valid);
      end
   end

   // Chain output = input accepted d ce cycles ago (the capturing edge counts).
   function automatic logic [W-1:0] m_tail(input bit bwd, input int d);
      int n = q_si.size();
      if (n < d) return '0;
      return bwd ? q_sbi[n-d] : q_si[n-d];
   endfunction

   // Primed = the last d accepted samples were all valid.
   function automatic bit m_primed(input int d);
      int n = q_v.size();
      if (n < d) return 1'b0;
      for (int i = n - d; i < n; i++) if (!q_v[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W-1:0] m_dout(input bit sub, output bit ovf);
      int           n = q_si.size();
      longint       a, b, r;
      logic [63:0]  t;
      ovf = 1'b0;
      if (n < 2) return '0;
      a = longint'(signed'(q_si[n-2]));
      b = longint'(signed'(q_sbi[n-2]));
      r = sub ? a - b : a + b;
      ovf = (r > MAXP) || (r < MINN);
`ifdef PADD_SAT_EN
      if (r > MAXP) r = MAXP;
      if (r < MINN) r = MINN;
`endif
      t = r;
      return t[W-1:0];
   endfunction

   function automatic bit m_dv(input int d);
      int n = q_v.size();
      return (n >= 2) && q_v[n-2] && m_primed(d);
   endfunction

   always @(negedge clk) begin : cmp
      bit o1, o4, o2;
      logic [W-1:0] e1, e4, e2;
      e1 = m_dout(1'b0, o1);
      e4 = m_dout(1'b0, o4);
      e2 = m_dout(1'b1, o2);
      chk("u1.so", so1, m_tail(0, 1));  chk("u1.sbo", sbo1, m_tail(1, 1));
      chk("u1.dout", d1, e1);           chk("u1.dv", dv1, m_dv(1));
      chk("u1.primed", pr1, m_primed(1));
      chk("u4.so", so4, m_tail(0, 4));  chk("u4.sbo", sbo4, m_tail(1, 4));
      chk("u4.dout", d4, e4);           chk("u4.dv", dv4, m_dv(4));
      chk("u4.primed", pr4, m_primed(4));
      chk("u2.so", so2, m_tail(0, 2));  chk("u2.sbo", sbo2, m_tail(1, 2));
      chk("u2.dout", d2, e2);           chk("u2.dv", dv2, m_dv(2));
      chk("u2.primed", pr2, m_primed(2));
`ifdef PADD_SAT_EN
      chk("u1.sat", sf1, o1); chk("u4.sat", sf4, o4); chk("u2.sat", sf2, o2);
`endif
   end

   // Present inputs, then return 2 time units after the edge that consumed them.
   task automatic cyc(input bit c, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
      ce = c; in_valid = v; si = a; sbi = b;
      @(posedge clk); #2;
   endtask

   function automatic logic [W-1:0] rnd_data();
      case ($urandom_range(7))
         0: return 18'h1FFFF;
         1: return 18'h20000;
         2: return 18'h3FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      resetn = 1'b0;
      repeat (3) cyc(1'b1, 1'b1, W'($urandom), W'($urandom));
      chk("rst.dout", d1, 0); chk("rst.so", so4, 0); chk("rst.primed", pr1, 0);

      // Release reset with ce held low: nothing may move.
      resetn = 1'b1;
      repeat (5) cyc(1'b0, 1'b1, W'($urandom), W'($urandom));
      chk("rel.dout", d1, 0); chk("rel.so", so1, 0); chk("rel.sbo", sbo1, 0);
      chk("rel.dv", dv1, 0);  chk("rel.primed", pr1, 0); chk("rel.so4", so4, 0);

      cyc(1'b1, 1'b1, 18'd100, 18'd23);
      chk("d1.so", so1, 100); chk("d1.sbo", sbo1, 23); chk("d1.primed", pr1, 1);
      cyc(1'b1, 1'b1, 18'd100, 18'd23);
      chk("d1.dout", d1, 123); chk("d1.dv", dv1, 1); chk("sub.dout", d2, 77);

      cyc(1'b1, 1'b1, 18'h1FFFF, 18'h20000);
      cyc(1'b1, 1'b1, 18'h0, 18'h0);
      chk("add.maxmin", d1, 18'h3FFFF);
`ifdef PADD_SAT_EN
      chk("sub.sat", d2, 18'h1FFFF); chk("sub.satflag", sf2, 1);
`else
      chk("sub.wrap", d2, 18'h3FFFF);
`endif

      resetn = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      resetn = 1'b1;
      // DEPTH=4 fill with ce high every other cycle.
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b1, W'(i), W'(50 + i));
         cyc(1'b1, 1'b1, W'(i), W'(50 + i));
         chk("fill.primed", pr4, (i == 4));
      end
      chk("fill.so", so4, 1); chk("fill.sbo", sbo4, 51);
      cyc(1'b1, 1'b1, 18'd5, 18'd55);
      chk("fill.so2", so4, 2); chk("fill.dv", dv4, 1);

      cyc(1'b1, 1'b0, 18'd6, 18'd56);
      chk("bub.primed", pr4, 0); chk("bub.dv", dv4, 0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 1'b1, W'(10 + i), W'(20 + i));
         chk("bub.refill", pr4, (i == 4));
      end

      // Partial-cycle reset pulse while primed.
      resetn = 1'b0; #1;
      chk("mrst.so", so4, 0); chk("mrst.dout", d4, 0); chk("mrst.dv", dv4, 0);
      chk("mrst.primed", pr4, 0); chk("mrst.primed1", pr1, 0);
      #1 resetn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 1'b1, W'(30 + i), W'(40 + i));
         chk("mrst.refill", pr4, (i == 4));
      end

      repeat (3000) begin
         if ($urandom_range(199) == 0) begin
            resetn = 1'b0;
            cyc(1'b1, 1'b1, rnd_data(), rnd_data());
            resetn = 1'b1;
         end else begin
            cyc($urandom_range(3) != 0, $urandom_range(9) != 0, rnd_data(), rnd_data());
         end
      end

      @(negedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
